// File: rtl/flash_resp_pkg.sv
// Shared opcodes, FSM states and status-bit layout for the SPI flash responder.
// The optional sector-erase path is enabled by FLASH_RESP_ERASE_EN.
package flash_resp_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'h20;

    localparam int ST_WIP = 0;
    localparam int ST_WEL = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DIN,
        S_DOUT,
        S_IGNORE,
        S_ERASE
    } state_t;

    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        logic [7:0] s;
        s         = 8'h00;
        s[ST_WEL] = wel;
        s[ST_WIP] = wip;
        return s;
    endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Two-flop synchronisers for SCK/CS_N/MOSI plus a third stage for edge pulses.
// SCK and MOSI share the same latency so MOSI is valid on the rise pulse.
module spi_resp_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sck,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_cs_fall,
    output logic o_cs_rise,
    output logic o_mosi_s
);

    logic [2:0] r_sck;
    logic [2:0] r_cs;
    logic [1:0] r_mosi;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sck  <= 3'b000;
            r_cs   <= 3'b111;
            r_mosi <= 2'b00;
        end else begin
            r_sck  <= {r_sck[1:0], i_sck};
            r_cs   <= {r_cs[1:0], i_cs_n};
            r_mosi <= {r_mosi[0], i_mosi};
        end
    end

    assign o_sck_rise = r_sck[1] & ~r_sck[2];
    assign o_sck_fall = ~r_sck[1] & r_sck[2];
    assign o_cs_fall  = ~r_cs[1] & r_cs[2];
    assign o_cs_rise  = r_cs[1] & ~r_cs[2];
    assign o_mosi_s   = r_mosi[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash target driving a byte-wide memory port.
// Define FLASH_RESP_ERASE_EN to enable 0x20 sector erase with WIP tracking.
module spi_flash_responder
    import flash_resp_pkg::*;
#(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4017,
    parameter int          PAGE_W   = 8,
    parameter int          SECTOR_W = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    output logic              busy
);

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_mosi;

    spi_resp_sync u_sync (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_sck      (spi_sck),
        .i_cs_n     (spi_cs_n),
        .i_mosi     (spi_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_cs_fall  (w_cs_fall),
        .o_cs_rise  (w_cs_rise),
        .o_mosi_s   (w_mosi)
    );

    state_t            r_state;
    state_t            w_next;
    state_t            w_dec;
    logic [2:0]        r_bitcnt;
    logic [1:0]        r_bytecnt;
    logic [7:0]        r_shin;
    logic [7:0]        r_shout;
    logic [7:0]        r_opcode;
    logic [7:0]        r_rdbuf;
    logic [22:0]       r_ashift;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_en;
    logic              r_rd_q;
    logic              r_wr_en;
    logic [7:0]        r_wdata;
    logic              r_wel;
    logic              r_wip;
    logic              r_wren;
    logic              r_wrdi;
    logic              r_pp_ok;
    logic              r_out_load;
    logic [1:0]        r_idx;

    logic              w_active;
    logic              w_byte_done;
    logic              w_cmd_done;
    logic              w_addr_done;
    logic [7:0]        w_shin_nx;
    logic [23:0]       w_addr_in;
    logic [ADDR_W-1:0] w_addr_full;
    logic              w_wren;
    logic              w_wrdi;
    logic              w_pp_acc;
    logic              w_se_acc;
    logic [7:0]        w_out_byte;

    assign w_active    = (r_state != S_IDLE) && (r_state != S_ERASE);
    assign w_byte_done = w_sck_rise & (r_bitcnt == 3'd7);
    assign w_cmd_done  = w_byte_done & (r_state == S_CMD);
    assign w_addr_done = w_byte_done & (r_state == S_ADDR) & (r_bytecnt == 2'd2);
    assign w_shin_nx   = {r_shin[6:0], w_mosi};
    assign w_addr_in   = {r_ashift, w_mosi};
    assign w_addr_full = w_addr_in[ADDR_W-1:0];

    // Events completing on the same cycle as CS rise still count.
    assign w_wren   = r_wren | (w_cmd_done & (w_shin_nx == OP_WREN) & ~r_wip);
    assign w_wrdi   = r_wrdi | (w_cmd_done & (w_shin_nx == OP_WRDI) & ~r_wip);
    assign w_pp_acc = r_pp_ok | (w_addr_done & (r_opcode == OP_PP) & r_wel);

`ifdef FLASH_RESP_ERASE_EN
    localparam logic [SECTOR_W:0] ECNT_END = {1'b1, {SECTOR_W{1'b0}}};

    logic              r_se_ok;
    logic [SECTOR_W:0] r_ecnt;
    logic [ADDR_W-1:0] w_se_addr;

    assign w_se_acc  = r_se_ok | (w_addr_done & (r_opcode == OP_SE) & r_wel);
    assign w_se_addr = w_addr_done ? w_addr_full : r_addr;
`else
    assign w_se_acc = 1'b0;
`endif

    always_comb begin
        w_dec = S_IGNORE;
        if (!r_wip || (w_shin_nx == OP_RDSR)) begin
            case (w_shin_nx)
                OP_RDSR, OP_RDID: w_dec = S_DOUT;
                OP_READ, OP_PP:   w_dec = S_ADDR;
`ifdef FLASH_RESP_ERASE_EN
                OP_SE:            w_dec = S_ADDR;
`endif
                default:          w_dec = S_IGNORE;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) w_next = S_CMD;
            end
            S_CMD: begin
                if (w_cmd_done) w_next = w_dec;
            end
            S_ADDR: begin
                if (w_addr_done) begin
                    if (r_opcode == OP_READ)
                        w_next = S_DOUT;
                    else if ((r_opcode == OP_PP) && r_wel)
                        w_next = S_DIN;
                    else
                        w_next = S_IGNORE;
                end
            end
`ifdef FLASH_RESP_ERASE_EN
            S_ERASE: begin
                if (w_cs_fall)
                    w_next = S_CMD;
                else if (!r_wip)
                    w_next = S_IDLE;
            end
`endif
            default: ;
        endcase
        if (w_cs_rise) w_next = w_se_acc ? S_ERASE : S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_out_byte = 8'h00;
        case (r_opcode)
            OP_RDSR: w_out_byte = status_byte(r_wel, r_wip);
            OP_RDID: begin
                case (r_idx)
                    2'd0:    w_out_byte = JEDEC_ID[23:16];
                    2'd1:    w_out_byte = JEDEC_ID[15:8];
                    2'd2:    w_out_byte = JEDEC_ID[7:0];
                    default: w_out_byte = 8'h00;
                endcase
            end
            // First byte after the address may arrive before the buffer fills.
            OP_READ: w_out_byte = r_rd_q ? mem_rdata : r_rdbuf;
            default: w_out_byte = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bitcnt   <= 3'd0;
            r_bytecnt  <= 2'd0;
            r_shin     <= 8'h00;
            r_shout    <= 8'h00;
            r_opcode   <= 8'h00;
            r_rdbuf    <= 8'h00;
            r_ashift   <= 23'd0;
            r_addr     <= '0;
            r_rd_en    <= 1'b0;
            r_rd_q     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wdata    <= 8'h00;
            r_wel      <= 1'b0;
            r_wip      <= 1'b0;
            r_wren     <= 1'b0;
            r_wrdi     <= 1'b0;
            r_pp_ok    <= 1'b0;
            r_out_load <= 1'b0;
            r_idx      <= 2'd0;
`ifdef FLASH_RESP_ERASE_EN
            r_se_ok    <= 1'b0;
            r_ecnt     <= '0;
`endif
        end else begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_rd_q  <= r_rd_en;
            if (r_rd_q) r_rdbuf <= mem_rdata;

            if (r_wr_en) begin
                if (r_wip)
                    r_addr <= {r_addr[ADDR_W-1:SECTOR_W],
                               r_addr[SECTOR_W-1:0] + 1'b1};
                else
                    r_addr <= {r_addr[ADDR_W-1:PAGE_W],
                               r_addr[PAGE_W-1:0] + 1'b1};
            end

            if (w_cs_fall) begin
                r_bitcnt   <= 3'd0;
                r_bytecnt  <= 2'd0;
                r_shout    <= 8'h00;
                r_out_load <= 1'b0;
            end

            if (w_sck_rise && w_active) begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_shin   <= w_shin_nx;
                if (r_state == S_ADDR) r_ashift <= w_addr_in[22:0];
                if (w_cmd_done) begin
                    r_opcode   <= w_shin_nx;
                    r_bytecnt  <= 2'd0;
                    r_idx      <= 2'd0;
                    r_out_load <= (w_dec == S_DOUT);
                    r_wren     <= (w_shin_nx == OP_WREN) & ~r_wip;
                    r_wrdi     <= (w_shin_nx == OP_WRDI) & ~r_wip;
                end
                if ((r_state == S_ADDR) && w_byte_done)
                    r_bytecnt <= r_bytecnt + 2'd1;
                if (w_addr_done) begin
                    r_addr  <= w_addr_full;
                    r_pp_ok <= (r_opcode == OP_PP) & r_wel;
`ifdef FLASH_RESP_ERASE_EN
                    r_se_ok <= (r_opcode == OP_SE) & r_wel;
`endif
                    if (r_opcode == OP_READ) begin
                        r_rd_en    <= 1'b1;
                        r_out_load <= 1'b1;
                    end
                end
                if ((r_state == S_DIN) && w_byte_done) begin
                    r_wr_en <= 1'b1;
                    r_wdata <= w_shin_nx;
                end
                if ((r_state == S_DOUT) && w_byte_done)
                    r_out_load <= 1'b1;
            end

            if (w_sck_fall && (r_state == S_DOUT)) begin
                if (r_out_load) begin
                    r_out_load <= 1'b0;
                    r_shout    <= w_out_byte;
                    if (r_opcode == OP_READ) begin
                        r_addr  <= r_addr + 1'b1;
                        r_rd_en <= 1'b1;
                    end
                    if ((r_opcode == OP_RDID) && (r_idx != 2'd3))
                        r_idx <= r_idx + 2'd1;
                end else begin
                    r_shout <= {r_shout[6:0], 1'b0};
                end
            end

`ifdef FLASH_RESP_ERASE_EN
            if (r_wip) begin
                if (r_ecnt == ECNT_END) begin
                    r_wip <= 1'b0;
                end else begin
                    r_wr_en <= 1'b1;
                    r_wdata <= 8'hFF;
                    r_ecnt  <= r_ecnt + 1'b1;
                end
            end
`endif

            if (w_cs_rise) begin
                r_bitcnt   <= 3'd0;
                r_shout    <= 8'h00;
                r_out_load <= 1'b0;
                r_wren     <= 1'b0;
                r_wrdi     <= 1'b0;
                r_pp_ok    <= 1'b0;
                if (w_wren) r_wel <= 1'b1;
                if (w_wrdi || w_pp_acc || w_se_acc) r_wel <= 1'b0;
`ifdef FLASH_RESP_ERASE_EN
                r_se_ok <= 1'b0;
                if (w_se_acc) begin
                    r_wip  <= 1'b1;
                    r_ecnt <= '0;
                    r_addr <= {w_se_addr[ADDR_W-1:SECTOR_W], {SECTOR_W{1'b0}}};
                end
`endif
            end
        end
    end

    assign spi_miso  = r_shout[7];
    assign mem_addr  = r_addr;
    assign mem_rd_en = r_rd_en;
    assign mem_wr_en = r_wr_en;
    assign mem_wdata = r_wdata;
    assign busy      = r_wip;

endmodule
